uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Parametrised UART receive front end, successor to the fixed 8N1 receiver in the I/O circuits. It adds configurable frame format, 16× oversampling with majority-vote sampling, start-bit glitch rejection, and per-byte parity/framing error reporting. It also adds overrun detection on a one-entry ready/valid output. It sits between the board serial pin and the CPU's memory-mapped UART/FIFO logic.

## Interface
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, line rate in baud
- OVERSAMPLE, 16, sample ticks per bit; even, ≥ 8
- DATA_BITS, 8, payload bits per frame; legal range 5–9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- serial_in  input  1  asynchronous line input; idle high, LSB first
- data_out  output  DATA_BITS  received payload
- data_out_valid  output  1  payload and error flags valid
- data_out_ready  input  1  consumer accepts; fire = valid & ready
- parity_error  output  1  parity mismatch on the held byte; always 0 when PARITY = 0
- framing_error  output  1  any stop bit sampled low on the held byte
- overrun  output  1  sticky; a completed frame was dropped because the holding register was full

## Operation
- serial_in passes through a 2-flop synchronizer; its reset value is 1. All logic uses the synchronized value.
- Tick generator: divisor DIV = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor. It emits a 1-cycle tick every DIV clocks. It free-runs in IDLE and is restarted on a start-edge detection.
- Bit sampling: a tick counter runs 0..OVERSAMPLE-1 per bit. Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority (2 of 3) of those samples. The bit is resolved at tick OVERSAMPLE/2+1.
- FSM states:
  - ARM: waits until the line is sampled high, then goes to IDLE. This is the reset state, and it is also entered after any frame whose last stop bit was low, so a stuck-low or break line is never re-triggered.
  - IDLE: a high-to-low transition starts a frame and moves to START.
  - START: if the majority is 1, the start is false; return to IDLE with no output. If the majority is 0, go to DATA.
  - DATA: DATA_BITS bits are shifted in LSB first. Then go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: the received bit is compared with the XOR of the data bits. Odd parity requires the total count of ones, including the parity bit, to be odd.
  - STOP: STOP_BITS bits are sampled. Any low stop bit sets the frame's framing flag. The frame completes at the resolution of the last stop bit. Then go to IDLE, or to ARM if the last stop bit was low.
- Completion when the holding register is empty, or when fire occurs in the same cycle: load data_out, parity_error and framing_error, and set data_out_valid.
- Completion when holding is full and there is no fire: the new frame is discarded, the held byte is unchanged, and overrun is set.
- overrun clears on the next fire, unless another overrun occurs in that same cycle.
- Fire with no completion: data_out_valid clears. data_out and the flags hold their values.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, parity_error = 0, framing_error = 0, overrun = 0, FSM = ARM.
- data_out_valid rises on the clk edge after the resolution tick of the last stop bit, nominally (1 + DATA_BITS + P + STOP_BITS - 0.5) bit periods after the falling start edge, plus 2 synchronizer cycles.
- The receiver re-arms immediately after completion, so back-to-back frames with no idle time are received.
- data_out_valid stays high until fire. It is never deasserted without fire.
- Reset asserted mid-frame aborts the frame at once, and all outputs take their reset values asynchronously.
- The counter widths are $clog2 of their maxima. Tick and bit counters wrap only under FSM control and never free-wrap.

## Structure
- Shared package uart_pkg holds:
  - parity enum: PAR_NONE, PAR_ODD, PAR_EVEN
  - rx state typedef: ARM, IDLE, START, DATA, PARITY, STOP
  - a function computing DIV
- One sub-module, uart_baud_tick (params CLOCK_FREQ, BAUD_RATE, OVERSAMPLE; inputs clk, reset_n, restart; output tick), to be reused by the matching transmitter.

## Test plan
Default parameters unless stated; DIV = 67, bit period = 1072 clocks.
- 8N1, send 0xA5 then 0x3C back-to-back with ready held high: data_out is 0xA5, then 0x3C. Each valid lasts 1 cycle. No flags set.
- 8E1, send 0x07 with parity bit 0: parity_error = 1 and data_out = 0x07. Resend 0x07 with parity bit 1: parity_error = 0.
- Low glitch of 200 clocks on an idle line: no data_out_valid. A frame 0x55 that follows it is received correctly.
- 8N2, send 0x81 with the second stop bit low: framing_error = 1. A break (line low for 20 bit periods) gives one frame of 0x00 with framing_error = 1 and no further frames until the line returns high.
- ready held low, send 0x11, 0x22: data_out = 0x11 and overrun = 1. After one fire, overrun = 0 and data_out_valid = 0.
- DATA_BITS = 5, PARITY = 1 (odd), send 0x1B, and assert reset_n low mid-data on a second frame: the first frame gives data_out = 0x1B with parity_error = 0. After the reset, all outputs are 0 and the next frame is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive front end and its matching
// transmitter: the parity-mode enum, the receiver state encoding and the
// baud-tick divisor calculation.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Parity mode; the numeric values match the integer PARITY parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Receiver state encoding, kept as plain constants so the values stay
    // stable across tools and match the older receiver's encoding.
    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_ARM    = 3'd0;
    localparam rx_state_t ST_IDLE   = 3'd1;
    localparam rx_state_t ST_START  = 3'd2;
    localparam rx_state_t ST_DATA   = 3'd3;
    localparam rx_state_t ST_PARITY = 3'd4;
    localparam rx_state_t ST_STOP   = 3'd5;

    // Clocks per oversample tick, rounded down.
    function automatic int unsigned baud_div(input int unsigned clock_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator. Emits a one-cycle tick every DIV clocks, where
// DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE). The count restarts from zero
// on 'restart' so the first tick after a start edge lands one full tick
// period later.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   restart  in   clear the divider; no tick is produced in that cycle
//   tick     out  one-cycle oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   DIV  = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// Parametrised UART receiver with OVERSAMPLE-times oversampling, 2-of-3
// majority voting around the bit centre, start-bit glitch rejection,
// parity/framing error flags per byte and a one-entry ready/valid holding
// register with sticky overrun.
//
// Ports
//   clk             in   system clock
//   reset_n         in   asynchronous active-low reset
//   serial_in       in   asynchronous line, idle high, LSB first
//   data_out        out  held payload
//   data_out_valid  out  holding register full
//   data_out_ready  in   consumer accepts (fire = valid & ready)
//   parity_error    out  parity mismatch on the held byte
//   framing_error   out  a stop bit of the held byte was sampled low
//   overrun         out  sticky: a finished frame was dropped
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);
    localparam bit          HAS_PAR  = (PAR_MODE != PAR_NONE);
    localparam bit          ODD_PAR  = (PAR_MODE == PAR_ODD);

    localparam int unsigned TW   = $clog2(OVERSAMPLE);
    localparam int unsigned BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    // Sample points straddle the bit centre; the bit resolves on the third.
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_RES  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

    // ---------------------------------------------------------------- sync
    logic [1:0] sync_q;
    logic       prev_q;
    logic       rx_s;

    assign rx_s = sync_q[1];

    // NOTE: sequential state always uses non-blocking assignments, so each
    // flop in the chain samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            prev_q <= rx_s;
        end
    end

    // ---------------------------------------------------------------- ticks
    rx_state_t          state_q, state_d;
    logic               start_edge;
    logic               tick;

    assign start_edge = (state_q == ST_IDLE) && prev_q && !rx_s;

    uart_baud_tick #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (start_edge),
        .tick    (tick)
    );

    // ---------------------------------------------------------------- FSM
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fpe_q, fpe_d;       // parity flag of frame in flight
    logic                 ffe_q, ffe_d;       // framing flag of frame in flight
    logic                 in_frame;
    logic                 resolve;
    logic                 maj;
    logic                 par_bad;
    logic                 complete;

    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign resolve  = in_frame && tick && (tick_cnt_q == T_RES);
    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    // XOR over data plus parity bit is 1 when the total count of ones is odd.
    assign par_bad  = ODD_PAR ? ~(^shift_q ^ maj) : (^shift_q ^ maj);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch appears.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        fpe_d      = fpe_q;
        ffe_d      = ffe_q;
        complete   = 1'b0;

        // Tick counter only advances inside a frame and wraps at the bit end.
        if (start_edge) begin
            tick_cnt_d = '0;
        end else if (in_frame && tick) begin
            tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        if (in_frame && tick && (tick_cnt_q == T_S0)) smp_d[0] = rx_s;
        if (in_frame && tick && (tick_cnt_q == T_S1)) smp_d[1] = rx_s;

        // State changes at the resolution tick; the tick counter keeps running
        // to the end of the bit, so the next resolution falls in the next bit.
        case (state_q)
            ST_ARM: begin
                if (rx_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    fpe_d     = 1'b0;
                    ffe_d     = 1'b0;
                end
            end
            ST_START: begin
                if (resolve) state_d = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (resolve) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == B_DLAST) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (resolve) begin
                    fpe_d   = par_bad;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (resolve) begin
                    ffe_d = ffe_q | ~maj;
                    if (bit_cnt_q == B_SLAST) begin
                        complete = 1'b1;
                        // A low final stop bit means a break or stuck line:
                        // wait for it to go high before accepting a new edge.
                        state_d  = maj ? ST_IDLE : ST_ARM;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // NOTE: the datapath registers (samples, shift register) are reset as
    // well; the cost is small and it keeps X out of data_out after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARM;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= 2'b11;
            shift_q    <= '0;
            fpe_q      <= 1'b0;
            ffe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            fpe_q      <= fpe_d;
            ffe_q      <= ffe_d;
        end
    end

    // ------------------------------------------------------- holding register
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 pe_q;
    logic                 fe_q;
    logic                 ovr_q;
    logic                 fire;

    assign fire = valid_q & data_out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (complete && (!valid_q || fire)) begin
                data_q  <= shift_q;
                pe_q    <= fpe_d;
                fe_q    <= ffe_d;
                valid_q <= 1'b1;
            end else if (fire) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a fire keeps the flag set.
            if (complete && valid_q && !fire) begin
                ovr_q <= 1'b1;
            end else if (fire) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign parity_error   = pe_q;
    assign framing_error  = fe_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Directed bench for uart_rx_oversampled. Five receivers share clk/reset:
//   a: defaults (8N1, DIV 67)         b: 8E1, fast clock (DIV 8)
//   c: 8N2, fast clock                d: 5O1, fast clock
//   e: 8N1, fast clock, ready under test control
// Accepted bytes are captured by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

    localparam int unsigned FAST_CLK = 14_745_600;   // 115200*16*8
    localparam int          BCLK_A   = 1072;
    localparam int          BCLK_F   = 128;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1, rx_d = 1'b1, rx_e = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1, rdy_d = 1'b1, rdy_e = 1'b0;

    logic [7:0] d_a, d_b, d_c, d_e;
    logic [4:0] d_d;
    logic v_a, v_b, v_c, v_d, v_e;
    logic pe_a, pe_b, pe_c, pe_d, pe_e;
    logic fe_a, fe_b, fe_c, fe_d, fe_e;
    logic ov_a, ov_b, ov_c, ov_d, ov_e;

    rec_t q_a[$], q_b[$], q_c[$], q_d[$];
    int   vcnt_a = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_oversampled u_a (
        .clk(clk), .reset_n(rst_n), .serial_in(rx_a), .data_out(d_a),
        .data_out_valid(v_a), .data_out_ready(rdy_a), .parity_error(pe_a),
        .framing_error(fe_a), .overrun(ov_a));

    uart_rx_oversampled #(.CLOCK_FREQ(FAST_CLK), .PARITY(2)) u_b (
        .clk(clk), .reset_n(rst_n), .serial_in(rx_b), .data_out(d_b),
        .data_out_valid(v_b), .data_out_ready(rdy_b), .parity_error(pe_b),
        .framing_error(fe_b), .overrun(ov_b));

    uart_rx_oversampled #(.CLOCK_FREQ(FAST_CLK), .STOP_BITS(2)) u_c (
        .clk(clk), .reset_n(rst_n), .serial_in(rx_c), .data_out(d_c),
        .data_out_valid(v_c), .data_out_ready(rdy_c), .parity_error(pe_c),
        .framing_error(fe_c), .overrun(ov_c));

    uart_rx_oversampled #(.CLOCK_FREQ(FAST_CLK), .DATA_BITS(5), .PARITY(1)) u_d (
        .clk(clk), .reset_n(rst_n), .serial_in(rx_d), .data_out(d_d),
        .data_out_valid(v_d), .data_out_ready(rdy_d), .parity_error(pe_d),
        .framing_error(fe_d), .overrun(ov_d));

    uart_rx_oversampled #(.CLOCK_FREQ(FAST_CLK)) u_e (
        .clk(clk), .reset_n(rst_n), .serial_in(rx_e), .data_out(d_e),
        .data_out_valid(v_e), .data_out_ready(rdy_e), .parity_error(pe_e),
        .framing_error(fe_e), .overrun(ov_e));

    // Capture every accepted byte; count valid cycles on receiver a.
    always @(negedge clk) begin
        if (v_a && rdy_a) q_a.push_back({9'(d_a), pe_a, fe_a});
        if (v_b && rdy_b) q_b.push_back({9'(d_b), pe_b, fe_b});
        if (v_c && rdy_c) q_c.push_back({9'(d_c), pe_c, fe_c});
        if (v_d && rdy_d) q_d.push_back({9'(d_d), pe_d, fe_d});
        if (v_a) vcnt_a++;
    end

    initial begin
        #1_500_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic set_line(input int id, input logic v);
        case (id)
            0: rx_a = v;
            1: rx_b = v;
            2: rx_c = v;
            3: rx_d = v;
            default: rx_e = v;
        endcase
    endtask

    // Drive n bits of 'bits', bit 0 first, each held for bclk clocks.
    task automatic send(input int id, input logic [31:0] bits, input int n, input int bclk);
        for (int i = 0; i < n; i++) begin
            set_line(id, bits[i]);
            repeat (bclk) @(negedge clk);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return q_a.size();
            1: return q_b.size();
            2: return q_c.size();
            default: return q_d.size();
        endcase
    endfunction

    // Bounded wait for a capture queue to reach n entries.
    task automatic wait_q(input int id, input int n, input int budget, input string name);
        int got;
        got = qsize(id);
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            got = qsize(id);
        end
        vectors++;
        if (got < n) begin
            $display("FAIL %s: captured %0d frames, required %0d", name, got, n);
            miscompares++;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors += 5;
        if ({d_a, v_a, pe_a, fe_a, ov_a} !== 12'h0) begin
            $display("FAIL reset_a: got %h required 0", {d_a, v_a, pe_a, fe_a, ov_a}); miscompares++;
        end
        if ({d_b, v_b, pe_b, fe_b, ov_b} !== 12'h0) begin
            $display("FAIL reset_b: got %h required 0", {d_b, v_b, pe_b, fe_b, ov_b}); miscompares++;
        end
        if ({d_c, v_c, pe_c, fe_c, ov_c} !== 12'h0) begin
            $display("FAIL reset_c: got %h required 0", {d_c, v_c, pe_c, fe_c, ov_c}); miscompares++;
        end
        if ({d_d, v_d, pe_d, fe_d, ov_d} !== 9'h0) begin
            $display("FAIL reset_d: got %h required 0", {d_d, v_d, pe_d, fe_d, ov_d}); miscompares++;
        end
        if ({d_e, v_e, pe_e, fe_e, ov_e} !== 12'h0) begin
            $display("FAIL reset_e: got %h required 0", {d_e, v_e, pe_e, fe_e, ov_e}); miscompares++;
        end
        rst_n = 1'b1;
        repeat (4 * BCLK_F) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        q_a.delete();
        vcnt_a = 0;
        // 0xA5 then 0x3C, 8N1, no idle gap between frames.
        send(0, {12'h0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, BCLK_A);
        set_line(0, 1'b1);
        wait_q(0, 2, 2 * BCLK_A, "b2b_count");
        if (q_a.size() >= 2) begin
            vectors += 2;
            if (q_a[0] !== {9'h0A5, 1'b0, 1'b0}) begin
                $display("FAIL b2b_first: got %h required %h", q_a[0], {9'h0A5, 2'b00}); miscompares++;
            end
            if (q_a[1] !== {9'h03C, 1'b0, 1'b0}) begin
                $display("FAIL b2b_second: got %h required %h", q_a[1], {9'h03C, 2'b00}); miscompares++;
            end
        end
        vectors += 2;
        if (vcnt_a !== 2) begin
            $display("FAIL b2b_valid_cycles: got %0d required 2", vcnt_a); miscompares++;
        end
        if (ov_a !== 1'b0) begin
            $display("FAIL b2b_overrun: got %b required 0", ov_a); miscompares++;
        end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = q_a.size();
        set_line(0, 1'b0);
        repeat (200) @(negedge clk);
        set_line(0, 1'b1);
        repeat (BCLK_A) @(negedge clk);
        vectors++;
        if (q_a.size() !== n0) begin
            $display("FAIL glitch_rejected: got %0d frames required %0d", q_a.size(), n0); miscompares++;
        end
        send(0, {22'h0, 1'b1, 8'h55, 1'b0}, 10, BCLK_A);
        wait_q(0, n0 + 1, BCLK_A, "glitch_followup_count");
        if (q_a.size() > n0) begin
            vectors++;
            if (q_a[n0] !== {9'h055, 1'b0, 1'b0}) begin
                $display("FAIL glitch_followup: got %h required %h", q_a[n0], {9'h055, 2'b00}); miscompares++;
            end
        end
    endtask

    task automatic test_parity;
        q_b.delete();
        // 0x07 has three ones: even parity needs a 1, so a 0 is an error.
        send(1, {21'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, BCLK_F);
        send(1, {21'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, BCLK_F);
        set_line(1, 1'b1);
        wait_q(1, 2, 2 * BCLK_F, "parity_count");
        if (q_b.size() >= 2) begin
            vectors += 2;
            if (q_b[0] !== {9'h007, 1'b1, 1'b0}) begin
                $display("FAIL parity_bad: got %h required %h", q_b[0], {9'h007, 2'b10}); miscompares++;
            end
            if (q_b[1] !== {9'h007, 1'b0, 1'b0}) begin
                $display("FAIL parity_good: got %h required %h", q_b[1], {9'h007, 2'b00}); miscompares++;
            end
        end
    endtask

    task automatic test_framing;
        q_c.delete();
        // 0x81 with first stop high, second stop low.
        send(2, {21'h0, 1'b0, 1'b1, 8'h81, 1'b0}, 11, BCLK_F);
        set_line(2, 1'b1);
        wait_q(2, 1, 4 * BCLK_F, "framing_count");
        if (q_c.size() >= 1) begin
            vectors++;
            if (q_c[0] !== {9'h081, 1'b0, 1'b1}) begin
                $display("FAIL framing_stop2: got %h required %h", q_c[0], {9'h081, 2'b01}); miscompares++;
            end
        end
        repeat (4 * BCLK_F) @(negedge clk);
        // Break: 20 bit periods low, then idle.
        q_c.delete();
        set_line(2, 1'b0);
        repeat (20 * BCLK_F) @(negedge clk);
        set_line(2, 1'b1);
        repeat (6 * BCLK_F) @(negedge clk);
        vectors++;
        if (q_c.size() !== 1) begin
            $display("FAIL break_frames: got %0d frames required 1", q_c.size()); miscompares++;
        end
        if (q_c.size() >= 1) begin
            vectors++;
            if (q_c[0] !== {9'h000, 1'b0, 1'b1}) begin
                $display("FAIL break_value: got %h required %h", q_c[0], {9'h000, 2'b01}); miscompares++;
            end
        end
    endtask

    task automatic test_overrun;
        send(4, {12'h0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}, 20, BCLK_F);
        set_line(4, 1'b1);
        repeat (BCLK_F) @(negedge clk);
        vectors += 3;
        if (d_e !== 8'h11) begin
            $display("FAIL overrun_held: got %h required 11", d_e); miscompares++;
        end
        if (v_e !== 1'b1) begin
            $display("FAIL overrun_valid: got %b required 1", v_e); miscompares++;
        end
        if (ov_e !== 1'b1) begin
            $display("FAIL overrun_set: got %b required 1", ov_e); miscompares++;
        end
        rdy_e = 1'b1;
        @(negedge clk);
        rdy_e = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (ov_e !== 1'b0) begin
            $display("FAIL overrun_clear: got %b required 0", ov_e); miscompares++;
        end
        if (v_e !== 1'b0) begin
            $display("FAIL overrun_valid_clear: got %b required 0", v_e); miscompares++;
        end
        if (d_e !== 8'h11) begin
            $display("FAIL overrun_data_hold: got %h required 11", d_e); miscompares++;
        end
    endtask

    task automatic test_reset_mid_frame;
        q_d.delete();
        // 0x1B has four ones: odd parity bit is 1.
        send(3, {24'h0, 1'b1, 1'b1, 5'h1B, 1'b0}, 8, BCLK_F);
        set_line(3, 1'b1);
        wait_q(3, 1, 2 * BCLK_F, "odd5_count");
        if (q_d.size() >= 1) begin
            vectors++;
            if (q_d[0] !== {9'h01B, 1'b0, 1'b0}) begin
                $display("FAIL odd5_frame: got %h required %h", q_d[0], {9'h01B, 2'b00}); miscompares++;
            end
        end
        repeat (2 * BCLK_F) @(negedge clk);
        // Start a frame and abort it in the middle of the data bits.
        send(3, {27'h0, 5'b00110}, 4, BCLK_F);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({d_d, v_d, pe_d, fe_d, ov_d} !== 9'h0) begin
            $display("FAIL reset_async: got %h required 0", {d_d, v_d, pe_d, fe_d, ov_d}); miscompares++;
        end
        set_line(3, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BCLK_F) @(negedge clk);
        q_d.delete();
        // 0x0A has two ones: odd parity bit is 1.
        send(3, {24'h0, 1'b1, 1'b1, 5'h0A, 1'b0}, 8, BCLK_F);
        set_line(3, 1'b1);
        wait_q(3, 1, 2 * BCLK_F, "post_reset_count");
        if (q_d.size() >= 1) begin
            vectors++;
            if (q_d[0] !== {9'h00A, 1'b0, 1'b0}) begin
                $display("FAIL post_reset_frame: got %h required %h", q_d[0], {9'h00A, 2'b00}); miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_parity();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
